led_matrix_scan: RTL

- Parametrised scanner for the organ's bicolour (red/green) LED dot matrix.
- Scans ROWS rows, one row per DWELL clocks, and draws a staircase bar pattern.
- Mixes colour per octave mode using per-row PWM. Yellow uses a programmable red:green duty ratio.
- Blanks the column of each pressed key. Sits between the keyboard/octave-switch logic and the matrix pins.

---
 rtl/led_scan_pkg.sv | 13 +
 rtl/led_scan_timer.sv | 47 ++++
 rtl/led_matrix_scan.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants and helpers for the bicolour LED matrix scanner.
package led_scan_pkg;

  localparam logic [2:0] MODE_HIGH = 3'b001;
  localparam logic [2:0] MODE_MID  = 3'b010;
  localparam logic [2:0] MODE_LOW  = 3'b100;

  // Staircase bar: row r lights columns 0..r.
  function automatic logic stair_bit(input int unsigned row_idx, input int unsigned col);
    return (col <= row_idx);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Dwell and row counters for the matrix scan, with frame boundary strobes.
module led_scan_timer #(
  parameter  int ROWS  = 8,
  parameter  int DWELL = 16,
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] dwell_cnt_o,
  output logic [RW-1:0] row_idx_o,
  output logic          frame_wrap_o,
  output logic          frame_start_next_o
);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] row_q, row_d;
  logic          dwell_wrap;

  always_comb begin
    dwell_wrap = (dwell_q == DWELL_LAST);
    dwell_d    = dwell_wrap ? '0 : dwell_q + 1'b1;
    row_d      = row_q;
    if (dwell_wrap) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
    end
  end

  assign dwell_cnt_o        = dwell_q;
  assign row_idx_o          = row_q;
  assign frame_wrap_o       = dwell_wrap && (row_q == ROW_LAST);
  assign frame_start_next_o = (dwell_q == '0) && (row_q == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Bicolour LED matrix scanner: staircase bars, per-mode PWM colour mixing
// and key-driven column blanking, with all matrix pins registered.
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int KEYS     = 7,
  parameter int PWM_BITS = 3,
  parameter int DWELL    = 16,
  parameter int BLANK    = 1,
  parameter int Y_R_DUTY = 2,
  parameter int Y_G_DUTY = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mode,
  input  logic [KEYS-1:0] key,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] col_r,
  output logic [COLS-1:0] col_g,
  output logic            frame_start
);

  localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NK  = (KEYS < COLS) ? KEYS : COLS;
  localparam int PW1 = PWM_BITS + 1;

  localparam logic [PWM_BITS:0] DUTY_FULL = PW1'(2 ** PWM_BITS);
  localparam logic [PWM_BITS:0] DUTY_YR   = PW1'(Y_R_DUTY);
  localparam logic [PWM_BITS:0] DUTY_YG   = PW1'(Y_G_DUTY);
  localparam logic [DW-1:0]     BLANK_C   = DW'(BLANK);

  logic [DW-1:0] dwell_cnt;
  logic [RW-1:0] row_idx;
  logic          frame_wrap;
  logic          frame_start_next;

  led_scan_timer #(
    .ROWS  (ROWS),
    .DWELL (DWELL)
  ) u_timer (
    .clk                (clk),
    .rst                (rst),
    .dwell_cnt_o        (dwell_cnt),
    .row_idx_o          (row_idx),
    .frame_wrap_o       (frame_wrap),
    .frame_start_next_o (frame_start_next)
  );

  logic [2:0]          mode_q;
  logic [KEYS-1:0]     key_q;
  logic [ROWS-1:0]     row_q, row_d;
  logic [COLS-1:0]     col_r_q, col_r_d;
  logic [COLS-1:0]     col_g_q, col_g_d;
  logic                frame_start_q;

  logic                mode_ok;
  logic [PWM_BITS:0]   duty_r, duty_g;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [COLS-1:0]     mask, kq, lit;
  logic                unblank, pwm_r_on, pwm_g_on;

  always_comb begin
    pwm_cnt = dwell_cnt[PWM_BITS-1:0];
    mode_ok = 1'b1;
    duty_r  = '0;
    duty_g  = '0;
    case (mode_q)
      MODE_HIGH: begin duty_r = DUTY_YR;   duty_g = DUTY_YG;   end
      MODE_MID:  begin duty_r = DUTY_FULL; duty_g = '0;        end
      MODE_LOW:  begin duty_r = '0;        duty_g = DUTY_FULL; end
      default:   mode_ok = 1'b0;
    endcase

    for (int c = 0; c < COLS; c++) begin
      mask[c] = stair_bit(32'(row_idx), unsigned'(c));
    end
    kq         = '0;
    kq[NK-1:0] = key_q[NK-1:0];

    // Columns stay dark for the first BLANK clocks of each row to hide ghosting.
    unblank  = (dwell_cnt >= BLANK_C);
    pwm_r_on = ({1'b0, pwm_cnt} < duty_r);
    pwm_g_on = ({1'b0, pwm_cnt} < duty_g);
    lit      = mask & ~kq & {COLS{unblank}};
    col_r_d  = lit & {COLS{pwm_r_on}};
    col_g_d  = lit & {COLS{pwm_g_on}};
    row_d    = mode_ok ? ~(ROWS'(1) << row_idx) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= mode;
      key_q         <= '0;
      row_q         <= '1;
      col_r_q       <= '0;
      col_g_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      // Mode only changes on the frame boundary so a frame is never mixed.
      if (frame_wrap) begin
        mode_q <= mode;
      end
      key_q         <= key;
      row_q         <= row_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      frame_start_q <= frame_start_next;
    end
  end

  assign row         = row_q;
  assign col_r       = col_r_q;
  assign col_g       = col_g_q;
  assign frame_start = frame_start_q;

endmodule
